// File: rtl/rv32v_radix4_multiplier.sv
// rtl/rv32v_radix4_multiplier.sv - iterative radix-4 WIDTHxWIDTH -> 2*WIDTH multiplier with sign fix-up
// Optional macro RV32V_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier digits are all zero.
module rv32v_radix4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    input  logic                 start,
    output logic                 finished,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH / 2 + 1);
    localparam logic [CW-1:0] DIGITS = CW'(WIDTH / 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH+1:0]       a_x3;
    logic [WIDTH-1:0]       b_shift;
    logic [2*WIDTH-1:0]     acc;
    logic [CW-1:0]          count;
    logic                   neg_result;

    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH+1:0]       pp;
    logic [2*WIDTH+1:0]     sum;
    logic [2*WIDTH-1:0]     acc_next;
    logic [2*WIDTH-1:0]     acc_final;
    logic [WIDTH-1:0]       b_next;
    logic                   last_digit;
`ifdef RV32V_MUL_EARLY_EXIT_EN
    logic [CW-1:0]          count_left;
`endif

    always_comb begin
        mag_a = (is_signed && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
        mag_b = (is_signed && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;

        case (b_shift[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, a_mag};
            2'd2:    pp = {1'b0, a_mag, 1'b0};
            default: pp = a_x3;
        endcase

        // Digit enters at weight 2^WIDTH; the bits shifted out below are always zero.
        sum      = {2'b00, acc} + {pp, {WIDTH{1'b0}}};
        acc_next = (2*WIDTH)'(sum >> 2);
        b_next   = b_shift >> 2;

`ifdef RV32V_MUL_EARLY_EXIT_EN
        count_left = count - CW'(1);
        last_digit = (count == CW'(1)) || (b_next == '0);
        acc_final  = acc_next >> {count_left, 1'b0};
`else
        last_digit = (count == CW'(1));
        acc_final  = acc_next;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            finished   <= 1'b0;
            busy       <= 1'b0;
            product    <= '0;
            a_mag      <= '0;
            a_x3       <= '0;
            b_shift    <= '0;
            acc        <= '0;
            count      <= '0;
            neg_result <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_mag      <= mag_a;
                        a_x3       <= {2'b00, mag_a} + {1'b0, mag_a, 1'b0};
                        b_shift    <= mag_b;
                        acc        <= '0;
                        count      <= DIGITS;
                        neg_result <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        state      <= BUSY;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    acc     <= acc_next;
                    b_shift <= b_next;
                    count   <= count - CW'(1);
                    if (last_digit) begin
                        product  <= neg_result ? -acc_final : acc_final;
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32v_radix4_multiplier.sv
// tb/tb_rv32v_radix4_multiplier.sv - self-checking bench for rv32v_radix4_multiplier
module tb_rv32v_radix4_multiplier;

`ifdef RV32V_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sgn = 1'b0;
    logic        start = 1'b0;
    logic        finished;
    logic [63:0] product;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int t0     = 0;

    // Transaction-level reference: one op in flight, retiring after its digit count.
    bit          m_pending = 0;
    int          m_due     = 0;
    logic [63:0] m_pend    = '0;
    logic [63:0] m_held    = '0;
    bit          m_fin     = 0;
    bit          m_busy    = 0;

    always #5 clk = ~clk;

    rv32v_radix4_multiplier #(.WIDTH(32)) dut (
        .CLK          (clk),
        .nRST         (nrst),
        .multiplicand (a),
        .multiplier   (b),
        .is_signed    (sgn),
        .start        (start),
        .finished     (finished),
        .product      (product),
        .busy         (busy)
    );

    function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y, logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Clock edges spent in BUSY: one per radix-4 digit, fewer with early exit.
    function automatic int lat_edges(logic [31:0] y, logic s);
        logic [31:0] m;
        int k;
        m = (s && y[31]) ? (32'd0 - y) : y;
        k = 1;
        while (k < 16 && (m >> (2 * k)) != 0) k++;
        return EARLY ? k : 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!nrst) begin
            m_pending = 0; m_held = '0; m_fin = 0; m_busy = 0;
        end else begin
            m_fin = 0;
            if (m_pending && cyc == m_due) begin
                m_held = m_pend; m_fin = 1; m_pending = 0; m_busy = 0;
            end else if (!m_pending && start) begin
                m_pending = 1;
                m_due     = cyc + lat_edges(b, sgn);
                m_pend    = ref_mul(a, b, sgn);
                m_busy    = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk("cyc_finished", {63'b0, finished}, {63'b0, m_fin});
            chk("cyc_busy", {63'b0, busy}, {63'b0, m_busy});
            chk("cyc_product", product, m_held);
        end
    end

    // Called at a negedge; returns just after the accepting posedge (plus hold busy edges).
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold);
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sgn = 1'($urandom);
            @(posedge clk);
        end
    endtask

    // Cycle numbering: the accepting edge closes cycle N, so edge N+k opens cycle N+k+1.
    task automatic wait_done(input string name, input logic [63:0] exp, input int exp_cyc,
                             input bit scramble, output int busy_cnt);
        bit got;
        got = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (finished) got = 1;
            else begin
                if (busy) busy_cnt++;
                if (scramble) begin
                    a = $urandom; b = $urandom; sgn = 1'($urandom);
                end
            end
        end
        chk({name, "_done"}, {63'b0, got}, 64'd1);
        chk({name, "_product"}, product, exp);
        chk({name, "_latency"}, 64'(cyc - t0 + 1), 64'(exp_cyc));
    endtask

    initial begin
        int bc;
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rs;

        repeat (2) @(negedge clk);
        chk("reset_finished", {63'b0, finished}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_product", product, 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        wait_done("umax", 64'hFFFFFFFE00000001, 17, 0, bc);
        chk("umax_busy_cycles", 64'(bc), 64'd16);
        @(negedge clk);

        start_op(32'hFFFFFFFD, 32'h00000007, 1'b1, 0);
        wait_done("sneg", 64'hFFFFFFFFFFFFFFEB, EARLY ? 3 : 17, 0, bc);
        @(negedge clk);

        start_op(32'h80000000, 32'h80000000, 1'b1, 0);
        wait_done("smin", 64'h4000000000000000, 17, 0, bc);
        @(negedge clk);

        start_op(32'h80000000, 32'h00000002, 1'b0, 0);
        wait_done("umsb", 64'h0000000100000000, EARLY ? 2 : 17, 0, bc);
        @(negedge clk);

        start_op(32'h00001234, 32'h00000010, 1'b0, 2);
        wait_done("held_start", 64'h12340, EARLY ? 4 : 17, 0, bc);
        start_op(32'd3, 32'd5, 1'b0, 0);
        wait_done("b2b", 64'hF, EARLY ? 3 : 17, 0, bc);
        @(negedge clk);

        start_op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 0);
        repeat (4) @(negedge clk);
        start = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        chk("midrst_product", product, 64'd0);
        chk("midrst_finished", {63'b0, finished}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        nrst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (finished) pulses++;
        end
        chk("midrst_no_pulse", 64'(pulses), 64'd0);
        start_op(32'd6, 32'd7, 1'b0, 0);
        wait_done("after_rst", 64'h2A, EARLY ? 3 : 17, 0, bc);
        @(negedge clk);

        start_op(32'h00010001, 32'h00030001, 1'b0, 0);
        wait_done("scramble", 64'h300040001, EARLY ? 10 : 17, 1, bc);
        @(negedge clk);

        start_op(32'h00000005, 32'h00000000, 1'b0, 0);
        wait_done("zero_b", 64'h0, EARLY ? 2 : 17, 0, bc);
        @(negedge clk);
        start_op(32'h00000007, 32'h00000003, 1'b1, 0);
        wait_done("small_b", 64'h15, EARLY ? 2 : 17, 0, bc);
        @(negedge clk);
        start_op(32'h00000001, 32'hFFFFFFFF, 1'b0, 0);
        wait_done("full_b", 64'hFFFFFFFF, 17, 0, bc);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom);
            start_op(ra, rb, rs, 0);
            wait_done("rand", ref_mul(ra, rb, rs), lat_edges(rb, rs) + 1, 0, bc);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32v_radix4_multiplier.md
Name: rv32v_radix4_multiplier

Overview:
- Iterative 32x32 -> 64-bit integer multiplier. It is the responder side of the start/finished handshake driven by the vector lane multiply unit.
- Retires 2 multiplier bits per cycle (radix-4 shift-add over magnitudes) and applies a sign fix-up for signed operation.
- One instance per vector lane. The multiply unit selects the SEW8/16/32 high/low slices from the full 64-bit product.

Parameters:
- WIDTH, 32, operand width; must be even; product is 2*WIDTH.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset; synchronous, active-low
- multiplicand  input  WIDTH  operand A (vs2 element)
- multiplier  input  WIDTH  operand B (vs1 element)
- is_signed  input  1  1: both operands two's complement; 0: both unsigned
- start  input  1  request; sampled only in IDLE or DONE
- finished  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until the next finished pulse
- busy  output  1  high in BUSY state

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low.
- Reset state: IDLE. finished=0, busy=0, product=0. All internal registers are cleared.
- States: IDLE, BUSY, DONE.
- IDLE + start:
  - Latch magnitudes: |A|, |B| when is_signed=1, else raw operands.
  - Latch neg_result = is_signed & (A[msb] ^ B[msb]).
  - Precompute 3*|A| (WIDTH+2 bits).
  - Clear the accumulator, load count = WIDTH/2, go to BUSY.
- BUSY, each cycle:
  - Take digit d = B_shift[1:0]. Add d*|A| (0, 1x, 2x or 3x) at the current weight: accumulator add then shift right 2, or equivalent.
  - Shift B_shift right 2 and decrement count.
  - When count reaches 1, go to DONE on the next edge.
- Latency: start sampled at edge N. finished=1 during cycle N+WIDTH/2+1 (N+17 for WIDTH=32).
- Entering DONE:
  - product <= neg_result ? (0 - acc) : acc, truncated to 2*WIDTH.
  - finished=1 for exactly that one cycle.
- DONE, next cycle:
  - start=0: go to IDLE.
  - start=1: accepted as a new operation (back-to-back), go to BUSY. finished still pulses only in the DONE cycle.
- start in BUSY: ignored. No queuing, no restart.
- Operand inputs are sampled only on the accepting edge. Later changes have no effect.
- Magnitude edge case: |0x80000000| = 0x80000000, computed as unsigned WIDTH bits with no overflow. Signed MIN*MIN = 0x4000000000000000.
- product is stable outside DONE-entry edges. It is not cleared by a new start.
- nRST low in any state, including mid-BUSY: next edge returns to IDLE, product=0, finished=0. The in-flight operation is discarded.
- busy=1 exactly while in BUSY. It is 0 in IDLE and DONE.

Optional Feature:
- Macro RV32V_MUL_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if the remaining B_shift (after this cycle's shift) is zero, go to DONE next edge regardless of count.
  - The accumulator is right-aligned by the remaining count*2 bits in the DONE-entry path, using a barrel shift or equivalent, so product is identical to the full-latency result.
  - Minimum latency: finished at N+2, e.g. multiplier=0 or 1.
- Not defined: fixed latency WIDTH/2+1 for all operands.
- Product values are identical in both builds.

Test Plan:
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF, is_signed=0 -> product 0xFFFFFFFE00000001; finished exactly 17 cycles after start edge; busy high 16 cycles.
- Signed 0xFFFFFFFD x 0x00000007 -> 0xFFFFFFFFFFFFFFEB. Signed 0x80000000 x 0x80000000 -> 0x4000000000000000. Unsigned 0x80000000 x 2 -> 0x0000000100000000.
- start held high during BUSY of op1 (0x1234 x 0x10) -> ignored, product 0x12340. start in the DONE cycle with 3 x 5 -> second finished 17 cycles later, product 0xF. Previous product held in between.
- nRST=0 for one cycle at BUSY cycle 5 of 0xFFFF x 0xFFFF -> next cycle product=0, finished=0, busy=0, no finished pulse. A fresh 6 x 7 then gives 0x2A at 17 cycles.
- Operands changed every cycle after the accepting edge -> result matches the operands sampled at acceptance.
- RV32V_MUL_EARLY_EXIT_EN defined: 0x00000005 x 0x00000000 -> product 0, finished at N+2. 0x7 x 0x3 (signed, -? no: positive) -> 0x15 at N+2. 0x1 x 0xFFFFFFFF -> 17 cycles. Undefined build: all three take 17 cycles with the same products.
